// File: rtl/mem_word_transfer_unit.sv
// mem_word_transfer_unit
//
// Bus master for the byte-wide system Memory. It accepts 1/2/4-byte load/store
// requests from the control unit and runs them as consecutive single-byte
// Memory accesses. Store data is sent out one byte at a time, little-endian.
// Load data is collected byte by byte into a 32-bit word.
//
// Optional build macro:
//   MISALIGN_CHECK_EN  When defined, a misaligned 2-byte or 4-byte request does
//                      not touch Memory. It completes one cycle after accept
//                      with rsp_err=1. When undefined, any alignment is legal
//                      and rsp_err is tied to 0.
//
// Parameters:
//   ADDR_W      Memory address width
//   GAP_CYCLES  idle cycles (Mem_CS high) between consecutive bytes, 0..3
//
// Ports:
//   Clock        system clock, rising edge
//   Reset        asynchronous, active-low reset
//   req_valid    request present (ignored while busy)
//   req_ready    unit can accept a request (IDLE)
//   req_write    1 = store, 0 = load
//   req_size     00 = 1 byte, 01 = 2 bytes, 10/11 = 4 bytes
//   req_addr     address of byte 0
//   req_wdata    store data, little-endian
//   rsp_valid    one-cycle completion pulse
//   rsp_rdata    load data, zero-extended; 0 for stores; held until next completion
//   rsp_err      misalignment error, valid with rsp_valid
//   Mem_Address  Memory address
//   Mem_Data     Memory write data
//   Mem_WR       1 = write, 0 = read
//   Mem_CS       active-low chip select
//   MemOut       Memory read data (combinational read)
//   busy         transfer in progress

module mem_word_transfer_unit #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] Mem_Address,
  output logic [7:0]        Mem_Data,
  output logic              Mem_WR,
  output logic              Mem_CS,
  input  logic [7:0]        MemOut,
  output logic              busy
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StXfer = 2'd1;
  localparam logic [1:0] StGap  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  // Last value of the gap counter before returning to XFER.
  localparam logic [1:0] GapLast = (GAP_CYCLES == 0) ? 2'd0 : 2'(GAP_CYCLES - 1);

  logic [1:0]        stateQ, stateD;
  logic              writeQ, writeD;
  logic [1:0]        lastCntQ, lastCntD;   // byte index of the final byte (N-1)
  logic [ADDR_W-1:0] addrQ, addrD;
  logic [31:0]       wdataQ, wdataD;
  logic [1:0]        cntQ, cntD;
  logic [1:0]        gapCntQ, gapCntD;
  logic [31:0]       accQ, accD;           // load accumulator for the running transfer
  logic [31:0]       rspDataQ, rspDataD;   // response word, held between completions
  logic              reqMisaligned;
  logic              inXfer;

  // Size decode: 11 is reserved and handled as a 4-byte transfer.
  function automatic logic [1:0] sizeToLast(input logic [1:0] size);
    unique case (size)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

`ifdef MISALIGN_CHECK_EN
  assign reqMisaligned = ((req_size == 2'b01) && req_addr[0]) ||
                         (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign reqMisaligned = 1'b0;
`endif

  always_comb begin
    stateD   = stateQ;
    writeD   = writeQ;
    lastCntD = lastCntQ;
    addrD    = addrQ;
    wdataD   = wdataQ;
    cntD     = cntQ;
    gapCntD  = gapCntQ;
    accD     = accQ;
    rspDataD = rspDataQ;

    unique case (stateQ)
      StIdle: begin
        if (req_valid) begin
          writeD   = req_write;
          lastCntD = sizeToLast(req_size);
          addrD    = req_addr;
          wdataD   = req_wdata;
          cntD     = 2'd0;
          gapCntD  = 2'd0;
          accD     = 32'h0;
          if (reqMisaligned) begin
            // No Memory access: complete straight away with zero data.
            rspDataD = 32'h0;
            stateD   = StDone;
          end else begin
            stateD = StXfer;
          end
        end
      end

      StXfer: begin
        // Memory read is combinational; capture the byte at the end of this cycle.
        if (!writeQ) begin
          accD[8*cntQ +: 8] = MemOut;
        end
        if (cntQ == lastCntQ) begin
          // Stores never write the accumulator, so this yields 0 for them.
          rspDataD = accD;
          stateD   = StDone;
        end else if (GAP_CYCLES == 0) begin
          cntD = cntQ + 2'd1;
        end else begin
          gapCntD = 2'd0;
          stateD  = StGap;
        end
      end

      StGap: begin
        if (gapCntQ == GapLast) begin
          cntD   = cntQ + 2'd1;
          stateD = StXfer;
        end else begin
          gapCntD = gapCntQ + 2'd1;
        end
      end

      StDone: begin
        stateD = StIdle;
      end

      default: begin
        stateD = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      stateQ   <= StIdle;
      writeQ   <= 1'b0;
      lastCntQ <= 2'd0;
      addrQ    <= '0;
      wdataQ   <= 32'h0;
      cntQ     <= 2'd0;
      gapCntQ  <= 2'd0;
      accQ     <= 32'h0;
      rspDataQ <= 32'h0;
    end else begin
      stateQ   <= stateD;
      writeQ   <= writeD;
      lastCntQ <= lastCntD;
      addrQ    <= addrD;
      wdataQ   <= wdataD;
      cntQ     <= cntD;
      gapCntQ  <= gapCntD;
      accQ     <= accD;
      rspDataQ <= rspDataD;
    end
  end

`ifdef MISALIGN_CHECK_EN
  logic errQ, errD;

  always_comb begin
    errD = errQ;
    if ((stateQ == StIdle) && req_valid) begin
      errD = reqMisaligned;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      errQ <= 1'b0;
    end else begin
      errQ <= errD;
    end
  end

  assign rsp_err = errQ && (stateQ == StDone);
`else
  assign rsp_err = 1'b0;
`endif

  // Memory-side outputs are forced idle outside XFER so Mem_WR can never be
  // asserted while the chip is deselected.
  assign inXfer      = (stateQ == StXfer);
  assign Mem_CS      = !inXfer;
  assign Mem_WR      = inXfer && writeQ;
  assign Mem_Address = inXfer ? (addrQ + ADDR_W'(cntQ)) : '0;
  assign Mem_Data    = inXfer ? wdataQ[8*cntQ +: 8] : 8'h00;

  assign req_ready = (stateQ == StIdle);
  assign busy      = (stateQ != StIdle);
  assign rsp_valid = (stateQ == StDone);
  assign rsp_rdata = rspDataQ;

endmodule

// File: tb/tb_mem_word_transfer_unit.sv
// Testbench for mem_word_transfer_unit: one instance with GAP_CYCLES=0 and one
// with GAP_CYCLES=2, each attached to its own byte-wide memory model.

module tb_mem_word_transfer_unit;

  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  int tests = 0;
  int fails = 0;

  function automatic logic [7:0] initVal(input int a);
    return 8'((a * 37 + 5) ^ (a >> 8));
  endfunction

  // ---------------- instance 0: GAP_CYCLES = 0 ----------------
  logic        req_valid, req_ready, req_write, rsp_valid, rsp_err, Mem_WR, Mem_CS, busy;
  logic [1:0]  req_size;
  logic [15:0] req_addr, Mem_Address;
  logic [31:0] req_wdata, rsp_rdata;
  logic [7:0]  Mem_Data, MemOut;

  mem_word_transfer_unit #(.ADDR_W(16), .GAP_CYCLES(0)) dut (
    .Clock(Clock), .Reset(Reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .Mem_Address(Mem_Address), .Mem_Data(Mem_Data), .Mem_WR(Mem_WR), .Mem_CS(Mem_CS),
    .MemOut(MemOut), .busy(busy)
  );

  logic [7:0] mem    [0:65535];
  logic [7:0] refMem [0:65535];

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = initVal(i);
    forever begin
      @(posedge Clock);
      if (Mem_CS === 1'b0 && Mem_WR === 1'b1) mem[Mem_Address] <= Mem_Data;
    end
  end
  assign MemOut = mem[Mem_Address];

  // ---------------- instance 1: GAP_CYCLES = 2 ----------------
  logic        gReqValid, gReqReady, gReqWrite, gRspValid, gRspErr, gMemWR, gMemCS, gBusy;
  logic [1:0]  gReqSize;
  logic [15:0] gReqAddr, gMemAddress;
  logic [31:0] gReqWdata, gRspRdata;
  logic [7:0]  gMemData, gMemOut;

  mem_word_transfer_unit #(.ADDR_W(16), .GAP_CYCLES(2)) dutGap (
    .Clock(Clock), .Reset(Reset),
    .req_valid(gReqValid), .req_ready(gReqReady), .req_write(gReqWrite),
    .req_size(gReqSize), .req_addr(gReqAddr), .req_wdata(gReqWdata),
    .rsp_valid(gRspValid), .rsp_rdata(gRspRdata), .rsp_err(gRspErr),
    .Mem_Address(gMemAddress), .Mem_Data(gMemData), .Mem_WR(gMemWR), .Mem_CS(gMemCS),
    .MemOut(gMemOut), .busy(gBusy)
  );

  logic [7:0] mem2 [0:65535];

  initial begin
    for (int i = 0; i < 65536; i++) mem2[i] = initVal(i);
    forever begin
      @(posedge Clock);
      if (gMemCS === 1'b0 && gMemWR === 1'b1) mem2[gMemAddress] <= gMemData;
    end
  end
  assign gMemOut = mem2[gMemAddress];

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkResetVals(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    check({tag, "_mem_addr"}, 32'(Mem_Address), 32'd0);
    check({tag, "_mem_data"}, 32'(Mem_Data), 32'd0);
    check({tag, "_mem_wr"}, 32'(Mem_WR), 32'd0);
    check({tag, "_mem_cs"}, 32'(Mem_CS), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // One transaction on instance 0, checked cycle by cycle against the model:
  // bytes occupy the N cycles after accept, the response follows immediately.
  task automatic doTxn(input logic wr, input logic [1:0] sz, input logic [15:0] a,
                       input logic [31:0] wd, input bit holdValid);
    int          n;
    bit          mis;
    logic [31:0] expR;
    logic [15:0] ba;
    n   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    mis = 1'b0;
`ifdef MISALIGN_CHECK_EN
    mis = ((sz == 2'b01) && a[0]) || (sz[1] && (a[1:0] != 2'b00));
`endif
    @(negedge Clock);
    check("ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_addr = a; req_wdata = wd;
    @(negedge Clock);
    if (holdValid) begin
      // Garbage while busy must be ignored.
      req_write = 1'($urandom); req_size = 2'($urandom);
      req_addr = 16'($urandom); req_wdata = $urandom;
    end else begin
      req_valid = 1'b0;
    end
    expR = 32'h0;
    if (!mis) begin
      for (int k = 0; k < n; k++) begin
        ba = a + 16'(k);
        check("xfer_cs", 32'(Mem_CS), 32'd0);
        check("xfer_addr", 32'(Mem_Address), 32'(ba));
        check("xfer_wr", 32'(Mem_WR), 32'(wr));
        check("xfer_busy", 32'(busy), 32'd1);
        check("xfer_ready", 32'(req_ready), 32'd0);
        check("xfer_rsp_valid", 32'(rsp_valid), 32'd0);
        if (wr) begin
          check("xfer_data", 32'(Mem_Data), 32'(wd[8*k +: 8]));
          refMem[ba] = wd[8*k +: 8];
        end else begin
          expR[8*k +: 8] = refMem[ba];
        end
        @(negedge Clock);
      end
    end
    check("done_valid", 32'(rsp_valid), 32'd1);
    check("done_rdata", rsp_rdata, expR);
    check("done_err", 32'(rsp_err), 32'(mis));
    check("done_cs", 32'(Mem_CS), 32'd1);
    check("done_busy", 32'(busy), 32'd1);
    req_valid = 1'b0;
    if (wr && !mis) begin
      for (int k = 0; k < n; k++) begin
        ba = a + 16'(k);
        check("mem_content", 32'(mem[ba]), 32'(refMem[ba]));
      end
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    for (int i = 0; i < 65536; i++) refMem[i] = initVal(i);
    Reset = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_addr = 16'h0; req_wdata = 32'h0;
    gReqValid = 1'b0; gReqWrite = 1'b0; gReqSize = 2'b00; gReqAddr = 16'h0; gReqWdata = 32'h0;
    repeat (3) @(negedge Clock);
    checkResetVals("por");
    Reset = 1'b1;

    // 4-byte store to 0x0010
    doTxn(1'b1, 2'b10, 16'h0010, 32'hA1B2C3D4, 1'b0);
    // 2-byte load of 0x5A/0x7E at 0x0020
    doTxn(1'b1, 2'b01, 16'h0020, 32'h00007E5A, 1'b0);
    doTxn(1'b0, 2'b01, 16'h0020, 32'h0, 1'b1);
    check("load2_value", rsp_rdata, 32'h00007E5A);
    // 4-byte access across the top of the address space
    doTxn(1'b1, 2'b10, 16'hFFFE, 32'h11223344, 1'b0);
    doTxn(1'b0, 2'b10, 16'hFFFE, 32'h0, 1'b0);
    check("wrap_value", rsp_rdata, 32'h11223344);
    // Reserved size behaves as 4 bytes
    doTxn(1'b0, 2'b11, 16'h0010, 32'h0, 1'b0);
    // Misaligned 4-byte load (error in the checked build, plain load otherwise)
    doTxn(1'b0, 2'b10, 16'h0031, 32'h0, 1'b0);

    for (int r = 0; r < 40; r++) begin
      logic [15:0] ra;
      ra = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3)) : 16'($urandom);
      doTxn(1'($urandom), 2'($urandom), ra, $urandom, 1'($urandom));
    end

    // Reset in the middle of a 4-byte store, after bytes 0 and 1
    doTxn(1'b0, 2'b10, 16'h0010, 32'h0, 1'b0);   // leaves rsp_rdata non-zero
    @(negedge Clock);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10;
    req_addr = 16'h0200; req_wdata = 32'hCAFEBABE;
    @(negedge Clock);                            // byte 0 on the bus
    req_valid = 1'b0;
    @(negedge Clock);                            // byte 1 on the bus
    @(negedge Clock);                            // byte 2 on the bus
    Reset = 1'b0;
    #1;
    checkResetVals("mid_rst");
    refMem[16'h0200] = 8'hBE;
    refMem[16'h0201] = 8'hBA;
    for (int k = 0; k < 4; k++) begin
      check("rst_mem", 32'(mem[16'h0200 + k]), 32'(refMem[16'h0200 + k]));
    end
    @(negedge Clock);
    Reset = 1'b1;
    repeat (3) begin
      @(negedge Clock);
      check("rst_no_rsp", 32'(rsp_valid), 32'd0);
      check("rst_idle", 32'(busy), 32'd0);
    end

    // GAP_CYCLES=2 instance: 1-byte store with req_valid held high
    @(negedge gReqReady ? Clock : Clock);
    gReqValid = 1'b1; gReqWrite = 1'b1; gReqSize = 2'b00;
    gReqAddr = 16'h0040; gReqWdata = 32'h00000099;
    @(negedge Clock);
    check("gap1_cs", 32'(gMemCS), 32'd0);
    check("gap1_wr", 32'(gMemWR), 32'd1);
    check("gap1_addr", 32'(gMemAddress), 32'h0040);
    check("gap1_data", 32'(gMemData), 32'h99);
    @(negedge Clock);
    check("gap1_rsp", 32'(gRspValid), 32'd1);
    check("gap1_cs_done", 32'(gMemCS), 32'd1);
    check("gap1_ready_done", 32'(gReqReady), 32'd0);
    @(negedge Clock);
    check("gap1_idle_ready", 32'(gReqReady), 32'd1);
    check("gap1_idle_cs", 32'(gMemCS), 32'd1);
    check("gap1_mem", 32'(mem2[16'h0040]), 32'h99);
    gReqValid = 1'b0;

    // GAP_CYCLES=2 instance: 2-byte load with two idle cycles between bytes
    @(negedge Clock);
    gReqValid = 1'b1; gReqWrite = 1'b0; gReqSize = 2'b01; gReqAddr = 16'h0100;
    @(negedge Clock);
    gReqValid = 1'b0;
    check("gap2_b0_cs", 32'(gMemCS), 32'd0);
    check("gap2_b0_addr", 32'(gMemAddress), 32'h0100);
    for (int g = 0; g < 2; g++) begin
      @(negedge Clock);
      check("gap2_gap_cs", 32'(gMemCS), 32'd1);
      check("gap2_gap_wr", 32'(gMemWR), 32'd0);
      check("gap2_gap_busy", 32'(gBusy), 32'd1);
    end
    @(negedge Clock);
    check("gap2_b1_cs", 32'(gMemCS), 32'd0);
    check("gap2_b1_addr", 32'(gMemAddress), 32'h0101);
    @(negedge Clock);
    check("gap2_rsp", 32'(gRspValid), 32'd1);
    check("gap2_rdata", gRspRdata, {16'h0, initVal(16'h0101), initVal(16'h0100)});
    check("gap2_err", 32'(gRspErr), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
